// File: rtl/rv_mem_resp_if.sv
// ---------------------------------------------------------------------------
// rv_mem_resp_if -- memory request/response bus between the multicycle RISC-V
// core (master) and its memory responder (slave).
//
// Signals:
//   req    master->slave  request valid
//   memrw  master->slave  1 = write, 0 = read
//   addr   master->slave  32-bit byte address
//   wdata  master->slave  32-bit write data
//   wstrb  master->slave  byte-lane write enables (only with RV_MEM_BYTE_STROBE_EN)
//   rdata  slave->master  read data, valid with ready on a read, held afterwards
//   ready  slave->master  single-cycle completion pulse
//   err    slave->master  completion was a rejected access
//   busy   slave->master  a request is in flight
//
// Optional feature macro: RV_MEM_BYTE_STROBE_EN adds the wstrb lane.
// ---------------------------------------------------------------------------
interface rv_mem_resp_if;
  logic        req;
  logic        memrw;
  logic [31:0] addr;
  logic [31:0] wdata;
`ifdef RV_MEM_BYTE_STROBE_EN
  logic [3:0]  wstrb;
`endif
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
`ifdef RV_MEM_BYTE_STROBE_EN
    output wstrb,
`endif
    output req, memrw, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
`ifdef RV_MEM_BYTE_STROBE_EN
    input  wstrb,
`endif
    input  req, memrw, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/rv_mem_resp.sv
// ---------------------------------------------------------------------------
// rv_mem_resp -- memory responder for the multicycle RISC-V core.
//
// Accepts one single-word read or write at a time from the core, waits
// WAIT_CYCLES cycles, then completes it against an internal word-addressed
// RAM with a one-cycle ready pulse. Misaligned or out-of-range addresses are
// completed with err=1 instead of touching the RAM or rdata.
//
// Ports:
//   clk  clock
//   rst  asynchronous, active-high reset (RAM contents are kept)
//   bus  rv_mem_resp_if.slave: req/memrw/addr/wdata[/wstrb] in,
//        rdata/ready/err/busy out
//
// Parameters:
//   DEPTH_WORDS  RAM size in 32-bit words (power of two, >= 4)
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//   BASE_ADDR    byte address of word 0 (aligned to DEPTH_WORDS*4)
//
// Optional feature macro: RV_MEM_BYTE_STROBE_EN -- per-byte write enables
// taken from bus.wstrb and latched with the request.
// ---------------------------------------------------------------------------
module rv_mem_resp #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  rv_mem_resp_if.slave bus
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) * 32'd4;
  localparam logic [3:0]  WAIT_LOAD  = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;

  // Latched request
  logic        memrw_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
`ifdef RV_MEM_BYTE_STROBE_EN
  logic [3:0]  wstrb_q;
`endif

  logic [31:0] rdata_q;
  logic [31:0] mem [DEPTH_WORDS];

  // Access decode. In IDLE the live inputs are decoded so that a
  // zero-wait-state read can load rdata on the acceptance edge; in every
  // other state only the latched request is used.
  logic [31:0]      acc_addr;
  logic             acc_memrw;
  logic [31:0]      acc_off;
  logic             acc_bad;
  logic [IDX_W-1:0] acc_idx;

  assign acc_addr  = (state == ST_IDLE) ? bus.addr  : addr_q;
  assign acc_memrw = (state == ST_IDLE) ? bus.memrw : memrw_q;
  assign acc_off   = acc_addr - BASE_ADDR;
  assign acc_bad   = (acc_addr[1:0] != 2'b00) || (acc_addr < BASE_ADDR) ||
                     (acc_off >= SPAN_BYTES);
  assign acc_idx   = acc_off[IDX_W+1:2];

  logic ready_c, err_c, busy_c, accept, load_rdata, mem_we;

  // NOTE: every signal written here gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt  = state;
    ready_c    = 1'b0;
    err_c      = 1'b0;
    busy_c     = 1'b0;
    accept     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.req) begin
          accept    = 1'b1;
          state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        busy_c = 1'b1;
        if (wait_cnt == 4'd0) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        busy_c    = 1'b1;
        ready_c   = 1'b1;
        err_c     = acc_bad;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;   // illegal encoding: outputs stay at 0
    endcase
    // rdata is captured on the edge that enters RESP so it is stable for the
    // whole ready cycle; rejected reads and writes leave it untouched.
    load_rdata = (state != ST_RESP) && (state_nxt == ST_RESP) && !acc_memrw && !acc_bad;
    mem_we     = (state == ST_RESP) && acc_memrw && !acc_bad;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      memrw_q  <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
`ifdef RV_MEM_BYTE_STROBE_EN
      wstrb_q  <= 4'd0;
`endif
      rdata_q  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        memrw_q  <= bus.memrw;
        addr_q   <= bus.addr;
        wdata_q  <= bus.wdata;
`ifdef RV_MEM_BYTE_STROBE_EN
        wstrb_q  <= bus.wstrb;
`endif
        wait_cnt <= WAIT_LOAD;
      end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= 4'(wait_cnt - 4'd1);
      end
      if (load_rdata) rdata_q <= mem[acc_idx];
    end
  end

  // NOTE: the RAM array has no reset; clearing it would turn it into a
  // flop bank. A write still in RESP when rst rises is dropped by the gate.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
`ifdef RV_MEM_BYTE_STROBE_EN
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[acc_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
`else
      mem[acc_idx] <= wdata_q;
`endif
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_c;
  assign bus.err   = err_c;
  assign bus.busy  = busy_c;

endmodule

// File: tb/tb_rv_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_rv_mem_resp -- directed bench for rv_mem_resp.
//
// Two responders share one set of driven inputs: u_dut2 (WAIT_CYCLES=2) and
// u_dut0 (WAIT_CYCLES=0). Most scenarios observe u_dut2; the back-to-back
// scenario observes u_dut0. Both see identical write traffic, so their RAM
// contents stay in step. Inputs change and outputs are sampled 1 ns after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_rv_mem_resp;

  localparam int WAIT2 = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        memrw;
  logic [31:0] addr;
  logic [31:0] wdata;
`ifdef RV_MEM_BYTE_STROBE_EN
  logic [3:0]  wstrb;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rd_model;   // expected u_dut2 rdata

  always #5 clk = ~clk;

  rv_mem_resp_if bus2 ();
  rv_mem_resp_if bus0 ();

  assign bus2.req   = req;
  assign bus2.memrw = memrw;
  assign bus2.addr  = addr;
  assign bus2.wdata = wdata;
  assign bus0.req   = req;
  assign bus0.memrw = memrw;
  assign bus0.addr  = addr;
  assign bus0.wdata = wdata;
`ifdef RV_MEM_BYTE_STROBE_EN
  assign bus2.wstrb = wstrb;
  assign bus0.wstrb = wstrb;
`endif

  rv_mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT2), .BASE_ADDR(32'h0))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  rv_mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on u_dut2 with cycle-exact latency checks. For reads, d is
  // the expected read data (wdata is driven with ~d).
  task automatic run_w2(input logic rw, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input string name);
    logic [31:0] exp_rd;
    req = 1'b1; memrw = rw; addr = a; wdata = rw ? d : ~d;
    tick();
    req = 1'b0;
    if (bus2.busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_accept got=%b exp=1", name, bus2.busy); end
    n_checks++;
    for (int i = 0; i < WAIT2; i++) begin
      if (bus2.ready !== 1'b0) begin n_fail++; $display("FAIL %s ready_early cyc=%0d got=%b exp=0", name, i, bus2.ready); end
      n_checks++;
      tick();
    end
    exp_rd = (!rw && !exp_err) ? d : rd_model;
    if (bus2.ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_resp got=%b exp=1", name, bus2.ready); end
    n_checks++;
    if (bus2.err !== exp_err) begin n_fail++; $display("FAIL %s err got=%b exp=%b", name, bus2.err, exp_err); end
    n_checks++;
    if (bus2.rdata !== exp_rd) begin n_fail++; $display("FAIL %s rdata got=%h exp=%h", name, bus2.rdata, exp_rd); end
    n_checks++;
    rd_model = exp_rd;
    tick();
    if (bus2.ready !== 1'b0 || bus2.busy !== 1'b0) begin
      n_fail++; $display("FAIL %s after_resp ready=%b busy=%b exp 0/0", name, bus2.ready, bus2.busy);
    end
    n_checks++;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; memrw = 1'b0; addr = 32'h0; wdata = 32'h0;
`ifdef RV_MEM_BYTE_STROBE_EN
    wstrb = 4'hF;
`endif
    rd_model = 32'h0;
    tick(); tick();
    if ({bus2.ready, bus2.err, bus2.busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags2 got=%b exp=000", {bus2.ready, bus2.err, bus2.busy});
    end
    n_checks++;
    if (bus2.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata2 got=%h exp=0", bus2.rdata); end
    n_checks++;
    if ({bus0.ready, bus0.err, bus0.busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags0 got=%b exp=000", {bus0.ready, bus0.err, bus0.busy});
    end
    n_checks++;
    if (bus0.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0 got=%h exp=0", bus0.rdata); end
    n_checks++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    run_w2(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, "wr_10");
    run_w2(1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, "rd_10");
  endtask

  task automatic test_back_to_back();
    run_w2(1'b1, 32'h0, 32'hA5A5_0000, 1'b0, "pre_w0");
    run_w2(1'b1, 32'h4, 32'h0102_0304, 1'b0, "pre_w1");
    req = 1'b1; memrw = 1'b0; addr = 32'h0;
    tick();
    if (bus0.ready !== 1'b1 || bus0.rdata !== 32'hA5A5_0000) begin
      n_fail++; $display("FAIL b2b_first ready=%b rdata=%h exp 1/a5a50000", bus0.ready, bus0.rdata);
    end
    n_checks++;
    addr = 32'h4;   // req stays high through RESP
    tick();
    if (bus0.ready !== 1'b0 || bus0.busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_gap ready=%b busy=%b exp 0/0", bus0.ready, bus0.busy);
    end
    n_checks++;
    tick();
    if (bus0.ready !== 1'b1 || bus0.rdata !== 32'h0102_0304) begin
      n_fail++; $display("FAIL b2b_second ready=%b rdata=%h exp 1/01020304", bus0.ready, bus0.rdata);
    end
    n_checks++;
    req = 1'b0;
    tick();
    if (bus0.ready !== 1'b0) begin n_fail++; $display("FAIL b2b_end ready=%b exp=0", bus0.ready); end
    n_checks++;
    // u_dut2 accepted the read of word 0 and completes it here.
    rd_model = 32'hA5A5_0000;
    repeat (4) tick();
    if (bus2.rdata !== rd_model || bus2.busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_dut2 rdata=%h busy=%b exp %h/0", bus2.rdata, bus2.busy, rd_model);
    end
    n_checks++;
  endtask

  task automatic test_errors();
    run_w2(1'b0, 32'h12,   32'h0,         1'b1, "rd_misaligned");
    run_w2(1'b0, 32'h1000, 32'h0,         1'b1, "rd_out_of_range");
    run_w2(1'b1, 32'h12,   32'hBAD0_BAD0, 1'b1, "wr_misaligned");
    run_w2(1'b1, 32'h1010, 32'hBAD1_BAD1, 1'b1, "wr_out_of_range");
    run_w2(1'b0, 32'h10,   32'hDEAD_BEEF, 1'b0, "rd_word4_intact");
    run_w2(1'b1, 32'hFFC,  32'h7E57_0FFC, 1'b0, "wr_last_word");
    run_w2(1'b0, 32'hFFC,  32'h7E57_0FFC, 1'b0, "rd_last_word");
  endtask

  task automatic test_reset_mid();
    run_w2(1'b1, 32'h20, 32'h1111_1111, 1'b0, "wr_20_first");
    req = 1'b1; memrw = 1'b1; addr = 32'h20; wdata = 32'h2222_2222;
    tick();
    req = 1'b0;
    if (bus2.busy !== 1'b1 || bus0.ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre busy2=%b ready0=%b exp 1/1", bus2.busy, bus0.ready);
    end
    n_checks++;
    #2 rst = 1'b1;
    #1;
    if ({bus2.ready, bus2.busy, bus0.ready, bus0.busy} !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_flags got=%b exp=0000", {bus2.ready, bus2.busy, bus0.ready, bus0.busy});
    end
    n_checks++;
    tick();
    rst = 1'b0;
    rd_model = 32'h0;
    tick();
    run_w2(1'b0, 32'h20, 32'h1111_1111, 1'b0, "rd_20_after_rst");
  endtask

  task automatic test_req_drop();
    run_w2(1'b1, 32'h34, 32'h5555_5555, 1'b0, "pre_34");
    req = 1'b1; memrw = 1'b1; addr = 32'h30; wdata = 32'hCAFE_F00D;
    tick();
    req = 1'b0; memrw = 1'b0; addr = 32'h34; wdata = 32'h0BAD_F00D;
    if (bus2.ready !== 1'b0) begin n_fail++; $display("FAIL drop_wait0 ready=%b exp=0", bus2.ready); end
    n_checks++;
    tick();
    addr = 32'h12; wdata = 32'hFFFF_FFFF;
    if (bus2.ready !== 1'b0) begin n_fail++; $display("FAIL drop_wait1 ready=%b exp=0", bus2.ready); end
    n_checks++;
    tick();
    if (bus2.ready !== 1'b1 || bus2.err !== 1'b0 || bus2.rdata !== rd_model) begin
      n_fail++; $display("FAIL drop_resp ready=%b err=%b rdata=%h exp 1/0/%h", bus2.ready, bus2.err, bus2.rdata, rd_model);
    end
    n_checks++;
    tick();
    tick();
    tick();
    if (bus2.ready !== 1'b0 || bus2.busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_single ready=%b busy=%b exp 0/0", bus2.ready, bus2.busy);
    end
    n_checks++;
    addr = 32'h0;
    run_w2(1'b0, 32'h30, 32'hCAFE_F00D, 1'b0, "rd_30_latched");
    run_w2(1'b0, 32'h34, 32'h5555_5555, 1'b0, "rd_34_untouched");
  endtask

`ifdef RV_MEM_BYTE_STROBE_EN
  task automatic test_byte_strobe();
    wstrb = 4'hF;
    run_w2(1'b1, 32'h8, 32'hAABB_CCDD, 1'b0, "bs_full");
    wstrb = 4'b0101;
    run_w2(1'b1, 32'h8, 32'h1122_3344, 1'b0, "bs_partial");
    wstrb = 4'hF;
    run_w2(1'b0, 32'h8, 32'hAA22_CC44, 1'b0, "bs_rd_partial");
    wstrb = 4'h0;
    run_w2(1'b1, 32'h8, 32'hFFFF_FFFF, 1'b0, "bs_none");
    run_w2(1'b1, 32'hA, 32'hFFFF_FFFF, 1'b1, "bs_misaligned");
    wstrb = 4'hF;
    run_w2(1'b0, 32'h8, 32'hAA22_CC44, 1'b0, "bs_rd_final");
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_req_drop();
`ifdef RV_MEM_BYTE_STROBE_EN
    test_byte_strobe();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_mem_resp.md
Name: rv_mem_resp

Overview:
- Memory responder for the multicycle RISC-V core: the slave end of the core's memory request interface.
- Accepts single-word read/write requests and applies a programmable number of wait states.
- Serves data from an internal word-addressed RAM and returns a one-cycle ready pulse.
- Flags misaligned and out-of-range accesses instead of performing them.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; power of two, minimum 4.
- WAIT_CYCLES, 2, wait states between acceptance and response; range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  request valid; sampled only in IDLE.
- memrw  in  1  1 = write, 0 = read (same encoding as the core's memrw).
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data; valid while ready=1 for a read; held afterwards.
- ready  out  1  single-cycle completion pulse.
- err  out  1  asserted with ready when the access was rejected.
- busy  out  1  high from acceptance until the cycle after ready.

Behaviour:
- Reset values: state IDLE, ready=0, err=0, busy=0, rdata=0, wait counter=0. RAM contents are not cleared by rst.
- States:
  - IDLE: busy=0. If req=1, latch memrw, addr and wdata into request registers. Go to WAIT if WAIT_CYCLES>0, else to RESP.
  - WAIT: counter loads WAIT_CYCLES-1 on entry and decrements each cycle. At counter==0, go to RESP. Inputs are ignored.
  - RESP: perform the access from the latched request, assert ready for exactly one cycle, return to IDLE.
- Latency: req sampled at edge N gives ready high in cycle N+1+WAIT_CYCLES (WAIT_CYCLES=0 gives ready in cycle N+1).
- Back-to-back requests: the earliest next acceptance is the IDLE cycle after RESP. req held high through RESP is not re-accepted in RESP; it is accepted in the following IDLE cycle.
- Error check, on the latched address:
  - Rejected if addr[1:0]!=0, or if addr<BASE_ADDR, or if addr>=BASE_ADDR+DEPTH_WORDS*4.
  - For a rejected access in RESP: err=1, ready=1, no RAM write, rdata unchanged.
- Word index = (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits after the range check.
- Write: the RAM word is updated at the clock edge ending RESP. err=0; rdata is unchanged.
- Read: the RAM is read combinationally from the latched index. rdata is registered at the edge entering RESP, so it is valid throughout the ready cycle.
- Read after write to the same word returns the new data: the write completes before the next acceptance.
- req deasserted mid-transaction: no effect; the latched request completes.
- Input changes during WAIT or RESP: ignored; only latched values are used.
- Reset mid-transaction: immediate return to IDLE, ready/err/busy forced to 0, pending write discarded, RAM otherwise untouched.
- Unknown state encoding: recover to IDLE with outputs at reset values.

Optional Feature:
- RV_MEM_BYTE_STROBE_EN defined:
  - Adds input wstrb[3:0], latched with the request.
  - On a write, byte lane i is updated only if wstrb[i]=1. wstrb=0 gives a write with no RAM change and err=0.
  - A misaligned address is still rejected.
- Not defined: no wstrb port; every write updates all four bytes.

Test Plan:
- WAIT_CYCLES=2: write addr=0x10, wdata=0xDEADBEEF, then read 0x10 -> each ready exactly 3 cycles after req is sampled, err=0, read rdata=0xDEADBEEF.
- WAIT_CYCLES=0: reads 0x0 then 0x4 with req held high continuously -> ready pulses two cycles apart, no acceptance during RESP, rdata matches preloaded words.
- Read addr=0x12 (misaligned) and addr=BASE_ADDR+DEPTH_WORDS*4 -> ready=1 with err=1, rdata keeps its prior value, a later read of word 4 is unchanged.
- Write 0x20=0x11111111, then assert rst during the WAIT of a write 0x20=0x22222222 -> ready/busy=0 immediately, subsequent read of 0x20 returns 0x11111111.
- req dropped after 1 cycle while addr/wdata toggle during WAIT -> response uses the originally latched values, ready still pulses once.
- RV_MEM_BYTE_STROBE_EN: word 0x8=0xAABBCCDD, write wdata=0x11223344 with wstrb=4'b0101 -> read 0x8 returns 0xAA22CC44.
